// File: rtl/uart_axil_host_pkg.sv
// Shared register map, STAT/CTRL field positions, response codes and host FSM states
// for the AXI4-Lite UART host.
package uart_axil_host_pkg;

    localparam logic [31:0] STAT_OFS = 32'h0000_0000;
    localparam logic [31:0] CTRL_OFS = 32'h0000_0004;
    localparam logic [31:0] DATA_OFS = 32'h0000_0008;

    localparam int STAT_TX_BUSY = 0;
    localparam int STAT_RX_OK   = 1;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_PAR_EN_BIT   = 1;
    localparam int CTRL_PAR_EVEN_BIT = 2;
    localparam int CTRL_BAUD_LSB     = 16;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [3:0] {
        CFG_W,
        CFG_B,
        IDLE,
        STAT_R,
        RXD_AR,
        RXD_R,
        DATA_W,
        DATA_B,
        GAP
    } state_t;

endpackage

// File: rtl/uart_axil_host_chan.sv
// Single-outstanding AXI4-Lite access issuer: start launches one read or write, done pulses with the response.
// Valids held until their handshake; done/rdata/resp are combinational in the response handshake cycle.
module uart_axil_host_chan
    import uart_axil_host_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we,
    input  logic        abort,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  resp,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arprot,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_awaddr,
    output logic [2:0]  m_awprot,
    output logic        m_wvalid,
    input  logic        m_wready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_bvalid,
    output logic        m_bready,
    input  logic [1:0]  m_bresp
);

    assign m_arprot = 3'b000;
    assign m_awprot = 3'b000;
    assign m_wstrb  = 4'hF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_araddr  <= '0;
            m_awaddr  <= '0;
            m_wdata   <= '0;
        end else if (abort) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
        end else begin
            if (start) begin
                if (we) begin
                    m_awvalid <= 1'b1;
                    m_wvalid  <= 1'b1;
                    m_bready  <= 1'b1;
                    m_awaddr  <= addr;
                    m_wdata   <= wdata;
                end else begin
                    m_arvalid <= 1'b1;
                    m_araddr  <= addr;
                end
            end
            // bready is raised with AW so a B coincident with the last AW/W handshake is still taken
            if (m_awvalid && m_awready) m_awvalid <= 1'b0;
            if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
            if (m_bvalid && m_bready)   m_bready  <= 1'b0;
            if (m_arvalid && m_arready) begin
                m_arvalid <= 1'b0;
                m_rready  <= 1'b1;
            end
            if (m_rvalid && m_rready)   m_rready  <= 1'b0;
        end
    end

    assign done  = (m_rvalid && m_rready) || (m_bvalid && m_bready);
    assign rdata = m_rdata;
    assign resp  = m_bready ? m_bresp : m_rresp;

endmodule

// File: rtl/uart_axil_host.sv
// AXI4-Lite host for the UART register map: configures CTRL, polls STAT, moves bytes via DATA.
// STAT poll + DATA write takes >= 4 cycles; one byte held for rx; UART_HOST_TIMEOUT_EN adds a response watchdog.
module uart_axil_host
    import uart_axil_host_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h1000_6000,
    parameter logic [15:0] BAUD_DIV       = 16'h0008,
    parameter logic        PARITY_EN      = 1'b0,
    parameter logic        PARITY_EVEN    = 1'b0,
    parameter int          POLL_GAP       = 10,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [7:0]  rx_data,
    output logic        busy,
    output logic        err,
    output logic [7:0]  err_cnt,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arprot,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_awaddr,
    output logic [2:0]  m_awprot,
    output logic        m_wvalid,
    input  logic        m_wready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_bvalid,
    output logic        m_bready,
    input  logic [1:0]  m_bresp
);

    localparam logic [31:0] CTRL_VAL = (32'(BAUD_DIV) << CTRL_BAUD_LSB)
                                     | (32'(PARITY_EVEN) << CTRL_PAR_EVEN_BIT)
                                     | (32'(PARITY_EN) << CTRL_PAR_EN_BIT)
                                     | (32'h1 << CTRL_EN_BIT);

    state_t      state, state_nxt;
    logic        chan_start, chan_we, chan_done, abort;
    logic [31:0] chan_addr, chan_wdata, chan_rdata;
    logic [1:0]  chan_resp;
    logic        resp_ok, stat_rx_ok, stat_tx_busy, wait_st, err_evt, rx_full;
    logic [15:0] gap_cnt;
    logic        unused_rdata_bits;

    assign resp_ok      = (chan_resp == RESP_OKAY);
    // A failed STAT read reads as all-zero status
    assign stat_rx_ok   = resp_ok && chan_rdata[STAT_RX_OK];
    assign stat_tx_busy = resp_ok && chan_rdata[STAT_TX_BUSY];
    assign wait_st      = (state == CFG_B) || (state == STAT_R) || (state == RXD_R) || (state == DATA_B);
    assign err_evt      = (chan_done && !resp_ok) || abort;
    assign unused_rdata_bits = ^chan_rdata[31:8];

`ifdef UART_HOST_TIMEOUT_EN
    logic [31:0] wd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd_cnt <= '0;
        else     wd_cnt <= (wait_st && !chan_done && !abort) ? wd_cnt + 32'd1 : '0;
    end

    assign abort = wait_st && !chan_done && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CFG_W;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        chan_start = 1'b0;
        chan_we    = 1'b0;
        chan_addr  = BASE_ADDR + STAT_OFS;
        chan_wdata = '0;
        tx_ready   = 1'b0;
        case (state)
            CFG_W: begin
                chan_start = 1'b1;
                chan_we    = 1'b1;
                chan_addr  = BASE_ADDR + CTRL_OFS;
                chan_wdata = CTRL_VAL;
                state_nxt  = CFG_B;
            end
            CFG_B: if (chan_done) state_nxt = resp_ok ? IDLE : CFG_W;
            IDLE: if (tx_valid || !rx_full) begin
                chan_start = 1'b1;
                state_nxt  = STAT_R;
            end
            STAT_R: if (chan_done) begin
                if (stat_rx_ok && !rx_full)         state_nxt = RXD_AR;
                else if (!stat_tx_busy && tx_valid) state_nxt = DATA_W;
                else                                state_nxt = GAP;
            end
            RXD_AR: begin
                chan_start = 1'b1;
                chan_addr  = BASE_ADDR + DATA_OFS;
                state_nxt  = RXD_R;
            end
            RXD_R: if (chan_done) state_nxt = GAP;
            DATA_W: begin
                tx_ready   = 1'b1;
                chan_start = 1'b1;
                chan_we    = 1'b1;
                chan_addr  = BASE_ADDR + DATA_OFS;
                chan_wdata = {24'b0, tx_data};
                state_nxt  = DATA_B;
            end
            DATA_B: if (chan_done) state_nxt = GAP;
            GAP: if (gap_cnt == 16'(POLL_GAP - 1)) state_nxt = IDLE;
            default: state_nxt = CFG_W;
        endcase
        if (abort) state_nxt = (state == CFG_B) ? CFG_W : GAP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
            rx_full <= 1'b0;
            rx_data <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : '0;
            if (rx_full && rx_ready) begin
                rx_full <= 1'b0;
            end else if (state == RXD_R && chan_done && resp_ok) begin
                rx_full <= 1'b1;
                rx_data <= chan_rdata[7:0];
            end
            if (err_evt) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign rx_valid = rx_full;
    assign busy     = (state != IDLE) && (state != GAP);

    uart_axil_host_chan u_chan (
        .clk       (clk),
        .rst       (rst),
        .start     (chan_start),
        .we        (chan_we),
        .abort     (abort),
        .addr      (chan_addr),
        .wdata     (chan_wdata),
        .done      (chan_done),
        .rdata     (chan_rdata),
        .resp      (chan_resp),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_arprot  (m_arprot),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_awaddr  (m_awaddr),
        .m_awprot  (m_awprot),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_bresp   (m_bresp)
    );

endmodule

// File: tb/tb_uart_axil_host.sv
// Directed bench for uart_axil_host against a zero-wait AXI4-Lite UART slave model with an access log.
module tb_uart_axil_host;

    localparam logic [31:0] A_STAT = 32'h1000_6000;
    localparam logic [31:0] A_CTRL = 32'h1000_6004;
    localparam logic [31:0] A_DATA = 32'h1000_6008;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, busy, err;
    logic [7:0]  tx_data, rx_data, err_cnt;
    logic        m_arvalid, m_rvalid, m_rready, m_awvalid, m_wvalid, m_bvalid, m_bready;
    logic        m_arready, m_awready, m_wready;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic [2:0]  m_arprot, m_awprot;
    logic [1:0]  m_rresp, m_bresp;
    logic [3:0]  m_wstrb;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } acc_t;

    acc_t        log_q[$];
    int          cyc = 0;
    int          n_txrdy = 0;
    logic        r_pend = 1'b0;
    logic        b_pend = 1'b0;
    logic [31:0] r_dat = '0;
    logic [31:0] stat_dflt = '0;
    logic [31:0] data_val = '0;
    logic [1:0]  bresp_val = 2'b00;
    logic        b_hold = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int s, w, c, e, r0, f;
    bit ok, stable;
    int rd_cyc[$];

    always #5 clk = ~clk;

    uart_axil_host dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .busy(busy), .err(err), .err_cnt(err_cnt),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
    );

    // Zero-wait slave: R/B follow one cycle after the address handshake
    assign m_arready = 1'b1;
    assign m_awready = 1'b1;
    assign m_wready  = 1'b1;
    assign m_rvalid  = r_pend;
    assign m_rdata   = r_dat;
    assign m_rresp   = 2'b00;
    assign m_bvalid  = b_pend && !b_hold;
    assign m_bresp   = bresp_val;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_arvalid && m_arready) begin
            r_pend <= 1'b1;
            r_dat  <= (m_araddr == A_STAT) ? stat_dflt : data_val;
            log_q.push_back('{1'b0, m_araddr, 32'h0, cyc});
        end
        if (m_rvalid && m_rready) r_pend <= 1'b0;
        if (m_awvalid && m_awready) begin
            b_pend <= 1'b1;
            log_q.push_back('{1'b1, m_awaddr, m_wdata, cyc});
        end
        if (m_bvalid && m_bready) b_pend <= 1'b0;
    end

    always @(negedge clk) if (tx_ready) n_txrdy <= n_txrdy + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int find_acc(input int from, input bit wr, input logic [31:0] addr);
        for (int i = from; i < log_q.size(); i++)
            if (log_q[i].wr == wr && log_q[i].addr == addr) return i;
        return -1;
    endfunction

    function automatic int count_acc(input int from, input int upto, input bit wr, input logic [31:0] addr);
        int n = 0;
        for (int i = from; i < upto && i < log_q.size(); i++)
            if (log_q[i].wr == wr && log_q[i].addr == addr) n++;
        return n;
    endfunction

    task automatic tx_wait_accept(input int budget, output bit acc, output int rdy_cyc);
        acc = 1'b0;
        rdy_cyc = 0;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                acc = 1'b1;
                rdy_cyc = cyc;
            end
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = rx_valid;
        end
    endtask

    task automatic rx_drain;
        @(negedge clk) rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awvalid", 32'(m_awvalid), 0);
        check("rst_wvalid",  32'(m_wvalid), 0);
        check("rst_bready",  32'(m_bready), 0);
        check("rst_arvalid", 32'(m_arvalid), 0);
        check("rst_rready",  32'(m_rready), 0);
        check("rst_awaddr",  m_awaddr, 0);
        check("rst_wdata",   m_wdata, 0);
        check("rst_wstrb",   32'(m_wstrb), 32'hF);
        check("rst_prot",    32'({m_arprot, m_awprot}), 0);
        check("rst_err",     32'({err, err_cnt}), 0);
        check("rst_rx_tx",   32'({rx_valid, tx_ready}), 0);
        check("rst_busy",    32'(busy), 1);

        // Configuration write comes first after reset release
        @(negedge clk) rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (log_q.size() >= 1);
        end
        check("cfg_seen", 32'(ok), 1);
        if (log_q.size() > 0) begin
            check("cfg_first_is_write", 32'(log_q[0].wr), 1);
            check("cfg_addr", log_q[0].addr, A_CTRL);
            check("cfg_data", log_q[0].data, 32'h0008_0001);
        end

        // Single byte with idle UART
        repeat (20) @(negedge clk);
        s = log_q.size(); r0 = n_txrdy;
        tx_data = 8'hA5; tx_valid = 1'b1;
        tx_wait_accept(200, ok, c);
        check("t2_accept", 32'(ok), 1);
        repeat (10) @(negedge clk);
        w = find_acc(s, 1'b1, A_DATA);
        check("t2_write_found", 32'(w >= 1), 1);
        if (w >= 1) begin
            check("t2_wdata", log_q[w].data, 32'h0000_00A5);
            check("t2_prev_is_stat_read", 32'({log_q[w-1].wr, log_q[w-1].addr == A_STAT}), 32'b01);
        end
        check("t2_tx_ready_cycles", 32'(n_txrdy - r0), 1);

        // TX busy for three polls, then free
        stat_dflt = 32'h1;
        repeat (30) @(negedge clk);
        s = log_q.size();
        tx_data = 8'h5A; tx_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = (count_acc(s, log_q.size(), 1'b0, A_STAT) >= 3);
        end
        check("t3_three_polls", 32'(ok), 1);
        stat_dflt = 32'h0;
        tx_wait_accept(200, ok, c);
        check("t3_accept", 32'(ok), 1);
        repeat (40) @(negedge clk);
        check("t3_single_write", 32'(count_acc(s, log_q.size(), 1'b1, A_DATA)), 1);
        w = find_acc(s, 1'b1, A_DATA);
        if (w < 0) w = log_q.size();
        else check("t3_wdata", log_q[w].data, 32'h0000_005A);
        rd_cyc.delete();
        for (int i = s; i < w; i++)
            if (!log_q[i].wr && log_q[i].addr == A_STAT) rd_cyc.push_back(log_q[i].cyc);
        check("t3_polls_before_write", 32'(rd_cyc.size()), 4);
        for (int i = 1; i < rd_cyc.size(); i++)
            check($sformatf("t3_poll_period%0d", i), 32'(rd_cyc[i] - rd_cyc[i-1]), 13);

        // RX byte held while the consumer stalls
        data_val = 32'h3C; stat_dflt = 32'h2;
        wait_rx(200, ok);
        check("t4_rx_valid", 32'(ok), 1);
        check("t4_rx_data", 32'(rx_data), 32'h3C);
        s = log_q.size();
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!rx_valid || rx_data !== 8'h3C) stable = 1'b0;
        end
        check("t4_rx_stable", 32'(stable), 1);
        check("t4_no_data_read", 32'(count_acc(s, log_q.size(), 1'b0, A_DATA)), 0);
        check("t4_idle_not_busy", 32'(busy), 0);
        stat_dflt = 32'h0;
        rx_drain();
        check("t4_rx_released", 32'(rx_valid), 0);

        // RX takes priority over TX when both are possible
        stat_dflt = 32'h1; data_val = 32'h99;
        tx_data = 8'h77; tx_valid = 1'b1;
        repeat (30) @(negedge clk);
        s = log_q.size();
        stat_dflt = 32'h3;
        wait_rx(200, ok);
        check("t5_rx_valid", 32'(ok), 1);
        check("t5_rx_data", 32'(rx_data), 32'h99);
        stat_dflt = 32'h0;
        tx_wait_accept(200, ok, c);
        check("t5_accept", 32'(ok), 1);
        repeat (10) @(negedge clk);
        f = find_acc(s, 1'b0, A_DATA);
        w = find_acc(s, 1'b1, A_DATA);
        check("t5_read_before_write", 32'(f >= 0 && w > f), 1);
        if (w >= 0) check("t5_wdata", log_q[w].data, 32'h0000_0077);
        rx_drain();

        // Error response on a DATA write
        repeat (20) @(negedge clk);
        bresp_val = 2'b10;
        s = log_q.size();
        tx_data = 8'hC3; tx_valid = 1'b1;
        tx_wait_accept(200, ok, c);
        check("t6_accept", 32'(ok), 1);
        repeat (40) @(negedge clk);
        check("t6_err", 32'(err), 1);
        check("t6_err_cnt", 32'(err_cnt), 1);
        check("t6_no_retry", 32'(count_acc(s, log_q.size(), 1'b1, A_DATA)), 1);
        bresp_val = 2'b00;

`ifdef UART_HOST_TIMEOUT_EN
        // B never arrives: watchdog aborts the write
        repeat (20) @(negedge clk);
        b_hold = 1'b1;
        tx_data = 8'h11; tx_valid = 1'b1;
        tx_wait_accept(200, ok, c);
        check("to_accept", 32'(ok), 1);
        e = 0;
        for (int i = 0; i < 2000 && e == 0; i++) begin
            @(negedge clk);
            if (err_cnt == 8'd2) e = cyc;
        end
        check("to_err_cnt", 32'(err_cnt), 2);
        check("to_abort_latency", 32'(e - c), 1025);
        check("to_lines_dropped", 32'({m_bready, m_awvalid, m_wvalid}), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
